// File: rtl/rvm_irq_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rvm_irq_ctrl_pkg
// Purpose : Shared constants and types for the machine external interrupt
//           controller: register offsets, source ID width, gateway state
//           encoding and the bus-decode bundle.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package rvm_irq_ctrl_pkg;

  // Byte offsets inside the controller's 16-byte window
  localparam logic [3:0] RVM_IRQ_ADDR_PENDING = 4'h0;
  localparam logic [3:0] RVM_IRQ_ADDR_ENABLE  = 4'h4;
  localparam logic [3:0] RVM_IRQ_ADDR_EDGE    = 4'h8;
  localparam logic [3:0] RVM_IRQ_ADDR_CLAIM   = 4'hC;

  // Source IDs are 5 bits; ID 0 is reserved for "no source"
  localparam int RVM_IRQ_ID_W = 5;

  // Per-source gateway state encoding
  localparam int         GW_STATE_W = 2;
  localparam logic [1:0] GW_IDLE    = 2'd0;
  localparam logic [1:0] GW_PEND    = 2'd1;
  localparam logic [1:0] GW_SERV    = 2'd2;

  // One-hot-ish decode of the current bus access
  typedef struct packed {
    logic rd_pending;
    logic rd_enable;
    logic rd_edge;
    logic rd_claim;
    logic wr_enable;
    logic wr_edge;
    logic wr_complete;
  } bus_dec_t;

  // Source index i reports ID i+1
  function automatic logic [RVM_IRQ_ID_W-1:0] src_to_id(input int unsigned idx);
    return RVM_IRQ_ID_W'(idx + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rvm_irq_ctrl_gateway.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rvm_irq_ctrl_gateway
// Purpose : One interrupt source's gateway: IDLE -> PEND -> SERV -> IDLE,
//           with level/edge trigger selection, rising-edge detect and a
//           one-deep latch for an edge arriving while in service.
// Ports   : clk        core clock
//           reset      synchronous active-high reset
//           line       (synchronised) device interrupt line
//           edge_mode  1 = edge-triggered, 0 = level-triggered
//           claim      a claim read selected this source this cycle
//           complete   a complete write carrying this source's ID
//           pending    source is in PEND
//           in_service source is in SERV
// Revision: 1.0  initial release
// ============================================================================
module rvm_irq_ctrl_gateway
  import rvm_irq_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic line,
  input  logic edge_mode,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service
);

  logic [GW_STATE_W-1:0] r_state;
  logic [GW_STATE_W-1:0] w_state_next;
  logic                  r_line_q;
  logic                  r_edge_flag;
  logic                  w_flag_next;
  logic                  w_rise;
  logic                  w_trigger;
  logic                  w_flag_set;

  assign w_rise     = line & ~r_line_q;
  assign w_trigger  = edge_mode ? w_rise : line;
  // Only edge sources remember a trigger seen outside IDLE
  assign w_flag_set = edge_mode & w_rise;

  always_comb begin
    w_state_next = r_state;
    w_flag_next  = r_edge_flag;
    case (r_state)
      GW_IDLE: begin
        w_flag_next = 1'b0;
        if (w_trigger) begin
          w_state_next = GW_PEND;
        end
      end
      GW_PEND: begin
        // An edge coinciding with the claim is kept for after completion
        if (claim) begin
          w_state_next = GW_SERV;
          w_flag_next  = w_flag_set;
        end else begin
          w_flag_next  = 1'b0;
        end
      end
      GW_SERV: begin
        if (complete) begin
          w_state_next = (r_edge_flag | w_flag_set) ? GW_PEND : GW_IDLE;
          w_flag_next  = 1'b0;
        end else begin
          w_flag_next  = r_edge_flag | w_flag_set;
        end
      end
      default: begin
        w_state_next = GW_IDLE;
        w_flag_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= GW_IDLE;
      r_line_q    <= 1'b0;
      r_edge_flag <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_line_q    <= line;
      r_edge_flag <= w_flag_next;
    end
  end

  assign pending    = (r_state == GW_PEND);
  assign in_service = (r_state == GW_SERV);

endmodule
`default_nettype wire

// File: rtl/rvm_irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rvm_irq_ctrl
// Purpose : Machine external interrupt controller. Latches NUM_SRC device
//           lines as pending, arbitrates the lowest-index enabled pending
//           source, drives trap_mei, and exposes a claim/complete register
//           interface on the core data bus (fixed one-cycle latency).
// Ports   : clk        core clock
//           reset      synchronous active-high reset
//           irq_src    device interrupt lines [NUM_SRC-1:0]
//           mem_req    bus access request (single-cycle pulse)
//           mem_wen    1 = write, 0 = read
//           mem_addr   byte offset: 0x0 PENDING, 0x4 ENABLE, 0x8 EDGE,
//                      0xC CLAIM (read) / COMPLETE (write)
//           mem_wdata  write data
//           mem_gnt    access-complete pulse, one cycle after mem_req
//           mem_rdata  read data, zero outside the grant cycle
//           trap_mei   some source is enabled, pending and not in service
// Revision: 1.0  initial release
// ============================================================================
module rvm_irq_ctrl
  import rvm_irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter bit SYNC_IN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mem_req,
  input  logic               mem_wen,
  input  logic [3:0]         mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic               mem_gnt,
  output logic [31:0]        mem_rdata,
  output logic               trap_mei
);

  logic [NUM_SRC-1:0]      w_line;
  logic [NUM_SRC-1:0]      r_enable;
  logic [NUM_SRC-1:0]      r_edge;
  logic [NUM_SRC-1:0]      w_pending;
  logic [NUM_SRC-1:0]      w_in_service;
  logic [NUM_SRC-1:0]      w_cand;
  logic [NUM_SRC-1:0]      w_claim;
  logic [NUM_SRC-1:0]      w_complete;
  logic                    w_found;
  logic [RVM_IRQ_ID_W-1:0] w_win_id;
  logic [RVM_IRQ_ID_W-1:0] w_cmp_id;
  logic                    w_rd;
  logic                    w_wr;
  bus_dec_t                w_dec;
  logic [31:0]             w_rdata;
  logic                    r_gnt;
  logic [31:0]             r_rdata;
  logic                    r_trap;
  logic                    w_unused_wdata;

  // --------------------------------------------------------------------------
  // Input synchroniser
  // --------------------------------------------------------------------------
  generate
    if (SYNC_IN) begin : g_sync
      logic [NUM_SRC-1:0] r_sync1;
      logic [NUM_SRC-1:0] r_sync2;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_sync1 <= '0;
          r_sync2 <= '0;
        end else begin
          r_sync1 <= irq_src;
          r_sync2 <= r_sync1;
        end
      end
      assign w_line = r_sync2;
    end else begin : g_nosync
      assign w_line = irq_src;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  assign w_rd     = mem_req & ~mem_wen;
  assign w_wr     = mem_req &  mem_wen;
  assign w_cmp_id = mem_wdata[RVM_IRQ_ID_W-1:0];
  // Upper write-data bits beyond the implemented sources are don't-care
  assign w_unused_wdata = ^mem_wdata;

  always_comb begin
    w_dec             = '0;
    w_dec.rd_pending  = w_rd && (mem_addr == RVM_IRQ_ADDR_PENDING);
    w_dec.rd_enable   = w_rd && (mem_addr == RVM_IRQ_ADDR_ENABLE);
    w_dec.rd_edge     = w_rd && (mem_addr == RVM_IRQ_ADDR_EDGE);
    w_dec.rd_claim    = w_rd && (mem_addr == RVM_IRQ_ADDR_CLAIM);
    w_dec.wr_enable   = w_wr && (mem_addr == RVM_IRQ_ADDR_ENABLE);
    w_dec.wr_edge     = w_wr && (mem_addr == RVM_IRQ_ADDR_EDGE);
    w_dec.wr_complete = w_wr && (mem_addr == RVM_IRQ_ADDR_CLAIM);
  end

  // --------------------------------------------------------------------------
  // Arbitration: lowest index among enabled, pending, not-in-service
  // --------------------------------------------------------------------------
  assign w_cand = w_pending & r_enable & ~w_in_service;

  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!w_found && w_cand[i]) begin
        w_found  = 1'b1;
        w_win_id = src_to_id(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-source gateways. ID 0 and IDs beyond NUM_SRC never match any
  // source, so out-of-range completes fall through with no effect.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign w_claim[gi]    = w_dec.rd_claim && w_found && (w_win_id == src_to_id(gi));
      assign w_complete[gi] = w_dec.wr_complete && (w_cmp_id == src_to_id(gi));

      rvm_irq_ctrl_gateway u_gateway (
        .clk        (clk),
        .reset      (reset),
        .line       (w_line[gi]),
        .edge_mode  (r_edge[gi]),
        .claim      (w_claim[gi]),
        .complete   (w_complete[gi]),
        .pending    (w_pending[gi]),
        .in_service (w_in_service[gi])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // ENABLE / EDGE registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable <= '0;
      r_edge   <= '0;
    end else begin
      if (w_dec.wr_enable) begin
        r_enable <= mem_wdata[NUM_SRC-1:0];
      end
      if (w_dec.wr_edge) begin
        r_edge <= mem_wdata[NUM_SRC-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read mux and registered outputs. Unmapped offsets and all writes
  // return zero but still receive a grant.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rdata = '0;
    if (w_dec.rd_pending) begin
      w_rdata[NUM_SRC-1:0] = w_pending;
    end
    if (w_dec.rd_enable) begin
      w_rdata[NUM_SRC-1:0] = r_enable;
    end
    if (w_dec.rd_edge) begin
      w_rdata[NUM_SRC-1:0] = r_edge;
    end
    if (w_dec.rd_claim) begin
      w_rdata[RVM_IRQ_ID_W-1:0] = w_win_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt   <= 1'b0;
      r_rdata <= '0;
      r_trap  <= 1'b0;
    end else begin
      r_gnt   <= mem_req;
      r_rdata <= w_rdata;
      r_trap  <= |w_cand;
    end
  end

  assign mem_gnt   = r_gnt;
  assign mem_rdata = r_rdata;
  assign trap_mei  = r_trap;

endmodule
`default_nettype wire
